// File: rtl/regfile_mp_if.sv
// Register-file bus: writeback port, scoreboard set port, packed read ports.
// The issue/decode side is the master; the register file is the slave.
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NR   = 2
);
   localparam int AW = $clog2(NREG);

   logic               WE;
   logic [AW-1:0]      A3;
   logic [XLEN-1:0]    WD3;
   logic [NR*AW-1:0]   RA;
   logic [NR*XLEN-1:0] RD;
   logic               SET_PEND;
   logic [AW-1:0]      A_SET;
   logic [NR-1:0]      BUSY;

   modport master (output WE, A3, WD3, RA, SET_PEND, A_SET, input RD, BUSY);
   modport slave  (input WE, A3, WD3, RA, SET_PEND, A_SET, output RD, BUSY);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending scoreboard.
// Reads are combinational, with optional same-cycle writeback forwarding.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NR       = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);
   localparam int AW = $clog2(NREG);
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic [XLEN-1:0]    regs [NREG];
   logic [NREG-1:0]    pend;
   logic [NREG-1:0]    pend_nxt;
   logic               we_ok;
   logic               set_ok;
   logic [AW-1:0]      ra_k;
   logic               hit_k;
   logic [NR*XLEN-1:0] rd_v;
   logic [NR-1:0]      busy_v;

   // An address is usable only if it exists and is not the hardwired zero.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      addr_ok = ({1'b0, a} < NREG_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign we_ok  = bus.WE && addr_ok(bus.A3);
   assign set_ok = bus.SET_PEND && addr_ok(bus.A_SET);

   // Set is applied after clear so a new producer supersedes the retiring one.
   always_comb begin
      pend_nxt = pend;
      if (we_ok)
         pend_nxt[bus.A3] = 1'b0;
      if (set_ok)
         pend_nxt[bus.A_SET] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         pend <= '0;
      end else begin
         if (we_ok)
            regs[bus.A3] <= bus.WD3;
         pend <= pend_nxt;
      end
   end

   always_comb begin
      rd_v   = '0;
      busy_v = '0;
      ra_k   = '0;
      hit_k  = 1'b0;
      for (int k = 0; k < NR; k++) begin
         ra_k  = bus.RA[k*AW +: AW];
         hit_k = (BYPASS != 0) && bus.WE && (bus.A3 == ra_k);
         if (!rst && addr_ok(ra_k)) begin
            rd_v[k*XLEN +: XLEN] = hit_k ? bus.WD3 : regs[ra_k];
            busy_v[k]            = pend[ra_k] && !hit_k;
         end
      end
   end

   assign bus.RD   = rd_v;
   assign bus.BUSY = busy_v;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with scoreboard, for the pipelined RISC-V core. It provides NR combinational read ports with optional write-to-read bypass and a hardwired-zero x0. It also keeps a per-register pending bit so the issue stage can stall on read-after-write hazards. It replaces the fixed 2-read/1-write register file in the decode stage.

## Interface
- XLEN, 32: register width in bits
- NREG, 32: number of architectural registers (2..64); AW = $clog2(NREG) is derived
- NR, 2: number of read ports (1..4)
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = read returns the stored value
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, never goes pending
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- WE  in  1  write enable (writeback)
- A3  in  AW  write address
- WD3  in  XLEN  write data
- RA  in  NR*AW  read addresses; port k = RA[k*AW +: AW]
- RD  out  NR*XLEN  read data; port k = RD[k*XLEN +: XLEN]
- SET_PEND  in  1  mark register A_SET as pending (issue of an instruction that writes it)
- A_SET  in  AW  register to mark pending
- BUSY  out  NR  BUSY[k] = value for port k is not yet available

## Operation
**Storage**
- NREG × XLEN data array `regs`.
- NREG-bit pending vector `pend`.

**Write, at the clock edge when WE=1:**
- regs[A3] <= WD3.
- The write is ignored if ZERO_REG=1 and A3=0.
- The write is ignored if A3 ≥ NREG.

**Read, port k, combinational**
- Define the address as "invalid" when (ZERO_REG && RA_k=0) or RA_k ≥ NREG.
- Priority:
  - rst=1 → 0.
  - Invalid address → 0.
  - BYPASS=1, WE=1 and A3=RA_k → WD3.
  - Otherwise → regs[RA_k].
- All ports are independent. Any number of ports may carry the same address.

**Pending vector, at the clock edge**
- The clear condition is WE=1: pend[A3] <= 0.
- The set condition is SET_PEND=1 with a valid A_SET: pend[A_SET] <= 1.
- If set and clear target the same register in the same cycle, set wins. The new producer supersedes the retiring one.
- Set and clear on different registers both take effect.
- SET_PEND with an invalid A_SET (0 when ZERO_REG=1, or ≥ NREG) is ignored.

**BUSY[k], combinational**
- 0 when rst=1 or the address is invalid.
- When BYPASS=1: pend[RA_k] && !(WE && A3=RA_k). Data arriving this cycle is forwarded, so the port is not busy.
- When BYPASS=0: pend[RA_k].

**Reset**
- rst=1 at an edge clears every regs entry to 0 and every pend bit to 0.
- rst overrides WE and SET_PEND in the same cycle.

## Timing
- Read latency is 0 cycles, combinational from RA/WE/A3/WD3/rst.
- A write is visible on a non-bypassed read in the cycle after the edge.
- With BYPASS=1 the write is visible in the same cycle.
- A pending bit set at edge n is seen on BUSY from cycle n+1 onward.
- It stays set until the edge of a WE cycle with a matching A3 and no simultaneous SET_PEND to the same register.
- Reset values (cycle after rst edge):
  - every RD = 0
  - every BUSY = 0
  - all regs = 0
  - pend = 0
- Outputs are also forced to 0 during every cycle in which rst=1.
- Reset asserted mid-sequence, with registers pending: all pending is lost. No write in the reset cycle lands.

## Test plan
- **Reset clear:**
  - Stimulus: write 0xDEADBEEF to x5; assert rst for one cycle; read RA0=5.
  - Required: RD0=0x00000000 and BUSY0=0 after the reset edge, and 0 during the rst cycle.
- **x0 hardwiring (ZERO_REG=1):**
  - Stimulus: WE=1, A3=0, WD3=0x12345678; SET_PEND with A_SET=0; read RA0=0 the same cycle and the next.
  - Required: RD0=0 and BUSY0=0 in both cycles.
- **Bypass vs no bypass:**
  - Stimulus: x7 holds 0x11111111; in one cycle drive WE=1, A3=7, WD3=0x22222222 with RA1=7.
  - Required with BYPASS=1: RD1=0x22222222 that cycle.
  - Required with BYPASS=0: RD1=0x11111111 that cycle, then 0x22222222 the next.
- **Scoreboard lifecycle:**
  - Stimulus: SET_PEND with A_SET=10 at edge n, then WE=1 with A3=10, WD3=0xCAFEF00D at cycle n+3.
  - Required: BUSY for RA=10 is 1 in cycles n+1..n+2.
  - Required at n+3: BUSY=0 with BYPASS=1, or 1 with BYPASS=0.
  - Required from n+4: BUSY=0 and RD=0xCAFEF00D.
- **Simultaneous set/clear, same register:**
  - Stimulus: x3 pending; in one cycle drive WE=1, A3=3, WD3=0xA5A5A5A5 and SET_PEND with A_SET=3.
  - Required next cycle: x3 still pending (BUSY=1) and RD=0xA5A5A5A5.
- **Multi-port, NR=4, NREG=24:**
  - Stimulus: RA={23, 23, 24, 31} after writing 0x0000ABCD to x23.
  - Required: RD={0xABCD, 0xABCD, 0, 0} and BUSY all 0.
  - Stimulus: write with A3=30.
  - Required: ignored; regs unchanged.
